// File: rtl/umi_pkg.sv
// Shared UMI definitions: opcodes, packet field offsets and endpoint FSM states.
package umi_pkg;

    localparam logic [7:0] UMI_REQ_READ   = 8'h01;
    localparam logic [7:0] UMI_REQ_WRITE  = 8'h02;
    localparam logic [7:0] UMI_REQ_POSTED = 8'h03;
    localparam logic [7:0] UMI_RESP_READ  = 8'h04;
    localparam logic [7:0] UMI_RESP_WRITE = 8'h05;
    localparam logic [7:0] UMI_RESP_ERR   = 8'h06;

    localparam int CMD_LSB  = 0;
    localparam int CMD_W    = 8;
    localparam int DST_LSB  = 32;
    localparam int SRC_LSB  = 96;
    localparam int ADDR_W   = 64;
    localparam int DATA_LSB = 160;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } ep_state_t;

    // True for opcodes that produce a local access.
    function automatic logic is_req(input logic [7:0] cmd);
        return (cmd == UMI_REQ_READ) || (cmd == UMI_REQ_WRITE) || (cmd == UMI_REQ_POSTED);
    endfunction

endpackage

// File: rtl/umi_pack.sv
// Assembles a UMI packet from its fields; all unassigned bits are zero.
module umi_pack
    import umi_pkg::*;
#(
    parameter int UW = 256,
    parameter int DW = 64
) (
    input  logic [CMD_W-1:0]  cmd,
    input  logic [ADDR_W-1:0] dstaddr,
    input  logic [ADDR_W-1:0] srcaddr,
    input  logic [DW-1:0]     data,
    output logic [UW-1:0]     packet
);

    always_comb begin
        packet                      = '0;
        packet[CMD_LSB +: CMD_W]    = cmd;
        packet[DST_LSB +: ADDR_W]   = dstaddr;
        packet[SRC_LSB +: ADDR_W]   = srcaddr;
        packet[DATA_LSB +: DW]      = data;
    end

endmodule

// File: rtl/umi_endpoint.sv
// UMI request/response endpoint bridging to a simple local access port.
// UMI_ENDPOINT_ERR_EN: answer unsupported opcodes with RESP_ERR instead of dropping them.
module umi_endpoint
    import umi_pkg::*;
#(
    parameter int UW = 256,
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          umi_in_valid,
    input  logic [UW-1:0] umi_in_packet,
    output logic          umi_in_ready,
    output logic          umi_out_valid,
    output logic [UW-1:0] umi_out_packet,
    input  logic          umi_out_ready,
    output logic          loc_valid,
    output logic          loc_write,
    output logic [AW-1:0] loc_addr,
    output logic [DW-1:0] loc_wrdata,
    input  logic          loc_ready,
    input  logic [DW-1:0] loc_rddata
);

    ep_state_t state_q, state_d;

    logic [CMD_W-1:0]  cmd_r;
    logic [ADDR_W-1:0] dst_r, src_r;
    logic [DW-1:0]     data_r;
    logic [CMD_W-1:0]  resp_cmd;
    logic [ADDR_W-1:0] resp_dst, resp_src;
    logic [DW-1:0]     resp_data;

    logic [CMD_W-1:0]  in_cmd;
    logic [ADDR_W-1:0] in_dst, in_src;
    logic [DW-1:0]     in_data;
    logic              in_xfer, loc_done;
    logic              unused_in;

    assign in_cmd    = umi_in_packet[CMD_LSB +: CMD_W];
    assign in_dst    = umi_in_packet[DST_LSB +: ADDR_W];
    assign in_src    = umi_in_packet[SRC_LSB +: ADDR_W];
    assign in_data   = umi_in_packet[DATA_LSB +: DW];
    assign unused_in = ^umi_in_packet;

    assign umi_in_ready  = (state_q == ST_IDLE);
    assign umi_out_valid = (state_q == ST_RESP);
    assign loc_valid     = (state_q == ST_ACCESS);
    assign loc_write     = loc_valid && (cmd_r != UMI_REQ_READ);
    assign loc_addr      = dst_r[AW-1:0];
    assign loc_wrdata    = data_r;
    assign in_xfer       = umi_in_valid && umi_in_ready;
    assign loc_done      = loc_valid && loc_ready;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_xfer) begin
                    if (is_req(in_cmd)) state_d = ST_ACCESS;
`ifdef UMI_ENDPOINT_ERR_EN
                    else                state_d = ST_RESP;
`endif
                end
            end
            ST_ACCESS: begin
                if (loc_done)
                    state_d = (cmd_r == UMI_REQ_POSTED) ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                if (umi_out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request fields only move on accepted requests, so the local port stays quiet otherwise.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cmd_r     <= '0;
            dst_r     <= '0;
            src_r     <= '0;
            data_r    <= '0;
            resp_cmd  <= '0;
            resp_dst  <= '0;
            resp_src  <= '0;
            resp_data <= '0;
        end else begin
            if (in_xfer && is_req(in_cmd)) begin
                cmd_r  <= in_cmd;
                dst_r  <= in_dst;
                src_r  <= in_src;
                data_r <= in_data;
            end
`ifdef UMI_ENDPOINT_ERR_EN
            if (in_xfer && !is_req(in_cmd)) begin
                resp_cmd  <= UMI_RESP_ERR;
                resp_dst  <= in_src;
                resp_src  <= in_dst;
                resp_data <= '0;
            end
`endif
            if (loc_done && (cmd_r != UMI_REQ_POSTED)) begin
                resp_cmd  <= (cmd_r == UMI_REQ_READ) ? UMI_RESP_READ : UMI_RESP_WRITE;
                resp_dst  <= src_r;
                resp_src  <= dst_r;
                resp_data <= (cmd_r == UMI_REQ_READ) ? loc_rddata : '0;
            end
        end
    end

    umi_pack #(
        .UW (UW),
        .DW (DW)
    ) u_pack (
        .cmd     (resp_cmd),
        .dstaddr (resp_dst),
        .srcaddr (resp_src),
        .data    (resp_data),
        .packet  (umi_out_packet)
    );

endmodule

// File: tb/tb_umi_endpoint.sv
// Scoreboard bench for umi_endpoint: expected responses queued at request time.
module tb_umi_endpoint;

    localparam int UW = 256;
    localparam int AW = 64;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          umi_in_valid = 1'b0;
    logic [UW-1:0] umi_in_packet = '0;
    logic          umi_in_ready;
    logic          umi_out_valid;
    logic [UW-1:0] umi_out_packet;
    logic          umi_out_ready = 1'b1;
    logic          loc_valid;
    logic          loc_write;
    logic [AW-1:0] loc_addr;
    logic [DW-1:0] loc_wrdata;
    logic          loc_ready = 1'b0;
    logic [DW-1:0] loc_rddata = '0;

    int total = 0;
    int bad   = 0;
    logic [UW-1:0] sb_q[$];

    umi_endpoint #(.UW(UW), .AW(AW), .DW(DW)) dut (
        .clk            (clk),
        .nreset         (nreset),
        .umi_in_valid   (umi_in_valid),
        .umi_in_packet  (umi_in_packet),
        .umi_in_ready   (umi_in_ready),
        .umi_out_valid  (umi_out_valid),
        .umi_out_packet (umi_out_packet),
        .umi_out_ready  (umi_out_ready),
        .loc_valid      (loc_valid),
        .loc_write      (loc_write),
        .loc_addr       (loc_addr),
        .loc_wrdata     (loc_wrdata),
        .loc_ready      (loc_ready),
        .loc_rddata     (loc_rddata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mkpkt(input logic [7:0] c, input logic [63:0] d,
                                           input logic [63:0] s, input logic [63:0] dat);
        logic [255:0] p;
        p          = '0;
        p[7:0]     = c;
        p[95:32]   = d;
        p[159:96]  = s;
        p[223:160] = dat;
        return p;
    endfunction

    // Drive one request with junk in the reserved bits; returns one cycle after the edge.
    task automatic send(input logic [7:0] c, input logic [63:0] d, input logic [63:0] s,
                        input logic [63:0] dat);
        logic [255:0] p;
        p            = mkpkt(c, d, s, dat);
        p[31:8]      = 24'hA5A5A5;
        p[255:224]   = 32'hF00DF00D;
        chk("in_ready_pre", umi_in_ready, 1);
        umi_in_valid  = 1'b1;
        umi_in_packet = p;
        @(negedge clk);
        umi_in_valid  = 1'b0;
        umi_in_packet = '0;
    endtask

    // Local responder: checks the held request, raises loc_ready after 'delay' cycles.
    task automatic loc_serve(input int delay, input logic [63:0] rd, input logic exp_wr,
                             input logic [63:0] exp_addr, input logic [63:0] exp_wd);
        int t;
        t = 0;
        while (!loc_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("loc_valid_seen", loc_valid, 1);
        if (loc_valid) begin
            for (int i = 0; i <= delay; i++) begin
                chk("loc_valid_hold", loc_valid, 1);
                chk("loc_write", loc_write, exp_wr);
                chk("loc_addr", loc_addr, exp_addr);
                chk("loc_wrdata", loc_wrdata, exp_wd);
                if (i == delay) begin
                    loc_ready  = 1'b1;
                    loc_rddata = rd;
                end
                @(negedge clk);
            end
            loc_ready  = 1'b0;
            loc_rddata = '0;
            chk("loc_valid_drop", loc_valid, 0);
        end
    endtask

    // Response monitor: pops the scoreboard on each transfer and checks stall stability.
    initial begin
        logic          stalled;
        logic [UW-1:0] prev;
        stalled = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk);
            #1;
            if (stalled) begin
                chk("out_hold_valid", umi_out_valid, 1);
                chk("out_hold_pkt", umi_out_packet, prev);
            end
            if (umi_out_valid && umi_out_ready) begin
                if (sb_q.size() == 0) chk("resp_unexpected", sb_q.size(), 1);
                else                  chk("resp_pkt", umi_out_packet, sb_q.pop_front());
            end
            stalled = umi_out_valid && !umi_out_ready;
            prev    = umi_out_packet;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_in_ready", umi_in_ready, 1);
        chk("rst_out_valid", umi_out_valid, 0);
        chk("rst_loc_valid", loc_valid, 0);
        chk("rst_loc_write", loc_write, 0);
        chk("rst_out_pkt", umi_out_packet, '0);
        chk("rst_loc_addr", loc_addr, '0);
        chk("rst_loc_wrdata", loc_wrdata, '0);
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;

        // READ accepted on the first edge after reset release, immediate loc_ready
        sb_q.push_back(mkpkt(8'h04, 64'h200, 64'h100, 64'hDEADBEEF));
        send(8'h01, 64'h100, 64'h200, 64'h0);
        chk("read_out_early", umi_out_valid, 0);
        loc_serve(0, 64'hDEADBEEF, 1'b0, 64'h100, 64'h0);
        chk("read_latency", umi_out_valid, 1);
        @(negedge clk);

        // WRITE with loc_ready 3 cycles late: 4 cycles of loc_valid
        sb_q.push_back(mkpkt(8'h05, 64'h80, 64'h40, 64'h0));
        send(8'h02, 64'h40, 64'h80, 64'h1234);
        loc_serve(3, 64'hFFFF, 1'b1, 64'h40, 64'h1234);
        chk("write_out_valid", umi_out_valid, 1);
        @(negedge clk);

        // POSTED_WRITE: local write only, ready again right after handshake
        send(8'h03, 64'h300, 64'h10, 64'hCAFE);
        loc_serve(0, 64'h0, 1'b1, 64'h300, 64'hCAFE);
        chk("posted_in_ready", umi_in_ready, 1);
        chk("posted_out_valid", umi_out_valid, 0);
        @(negedge clk);

        // READ with umi_out_ready low for 5 cycles
        umi_out_ready = 1'b0;
        sb_q.push_back(mkpkt(8'h04, 64'h600, 64'h500, 64'h55AA));
        send(8'h01, 64'h500, 64'h600, 64'h0);
        loc_serve(1, 64'h55AA, 1'b0, 64'h500, 64'h0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_in_ready", umi_in_ready, 0);
            chk("stall_out_valid", umi_out_valid, 1);
            @(negedge clk);
        end
        umi_out_ready = 1'b1;
        @(negedge clk);
        chk("post_stall_ready", umi_in_ready, 1);
        sb_q.push_back(mkpkt(8'h05, 64'h800, 64'h700, 64'h0));
        send(8'h02, 64'h700, 64'h800, 64'h99);
        loc_serve(0, 64'h0, 1'b1, 64'h700, 64'h99);
        @(negedge clk);

        // Unsupported opcode
`ifdef UMI_ENDPOINT_ERR_EN
        sb_q.push_back(mkpkt(8'h06, 64'hA00, 64'h900, 64'h0));
`endif
        send(8'h7F, 64'h900, 64'hA00, 64'h1);
        for (int i = 0; i < 4; i++) begin
            chk("bad_op_loc_valid", loc_valid, 0);
            @(negedge clk);
        end
        chk("bad_op_in_ready", umi_in_ready, 1);

        // Reset asserted mid-ACCESS: outputs drop at once, transaction lost
        send(8'h01, 64'hB00, 64'hB10, 64'h0);
        chk("pre_rst_loc_valid", loc_valid, 1);
        #2;
        nreset = 1'b0;
        #1;
        chk("arst_loc_valid", loc_valid, 0);
        chk("arst_in_ready", umi_in_ready, 1);
        chk("arst_out_valid", umi_out_valid, 0);
        chk("arst_loc_addr", loc_addr, '0);
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("arst_no_resp", umi_out_valid, 0);
            @(negedge clk);
        end

        sb_q.push_back(mkpkt(8'h04, 64'hD00, 64'hC00, 64'h77));
        send(8'h01, 64'hC00, 64'hD00, 64'h0);
        loc_serve(0, 64'h77, 1'b0, 64'hC00, 64'h0);
        repeat (4) @(negedge clk);

        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/umi_endpoint.md
UMI_ENDPOINT -- requirements
Module: umi_endpoint

Interface
REQ-001 SHALL have parameter UW, default 256, UMI packet width.
REQ-002 SHALL have parameter AW, default 64, local address width.
REQ-003 SHALL have parameter DW, default 64, local data width (DW <= 64).
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port nreset  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port umi_in_valid  input  1  request packet valid.
REQ-007 SHALL have port umi_in_packet  input  UW  request packet.
REQ-008 SHALL have port umi_in_ready  output  1  request accept.
REQ-009 SHALL have port umi_out_valid  output  1  response packet valid.
REQ-010 SHALL have port umi_out_packet  output  UW  response packet.
REQ-011 SHALL have port umi_out_ready  input  1  response accept.
REQ-012 SHALL have ports loc_valid (output, 1), loc_write (output, 1), loc_addr (output, AW), loc_wrdata (output, DW): local access request.
REQ-013 SHALL have ports loc_ready (input, 1) and loc_rddata (input, DW): local access completion; loc_rddata valid in the loc_ready cycle.

Function
REQ-014 Packet fields SHALL be: cmd [7:0], dstaddr [95:32], srcaddr [159:96], data [159+DW:160]; all other bits are zero on output and ignored on input.
REQ-015 Opcodes SHALL be: READ 0x01, WRITE 0x02, POSTED_WRITE 0x03, RESP_READ 0x04, RESP_WRITE 0x05, RESP_ERR 0x06.
REQ-016 A request SHALL transfer in a cycle where umi_in_valid & umi_in_ready; umi_in_ready = 1 only in IDLE.
REQ-017 FSM states SHALL be IDLE, ACCESS, RESP; one transaction outstanding at a time.
REQ-018 IDLE -> ACCESS on transfer of READ/WRITE/POSTED_WRITE; the packet's cmd, dstaddr, srcaddr, data are registered on that edge.
REQ-019 In ACCESS, loc_valid SHALL be 1, loc_write = (cmd != READ), loc_addr = dstaddr[AW-1:0], loc_wrdata = data; held stable until loc_ready.
REQ-020 ACCESS -> RESP on loc_valid & loc_ready for READ/WRITE; ACCESS -> IDLE for POSTED_WRITE (no response).
REQ-021 loc_rddata SHALL be captured on the loc_ready edge for READ; response data for WRITE is zero.
REQ-022 In RESP, umi_out_valid = 1; response cmd = RESP_READ or RESP_WRITE, dstaddr = request srcaddr, srcaddr = request dstaddr; packet held stable while umi_out_ready = 0.
REQ-023 RESP -> IDLE on umi_out_valid & umi_out_ready; next request accepted no earlier than the following cycle.
REQ-024 Minimum latency, request transfer to umi_out_valid, SHALL be 2 cycles (loc_ready high on first ACCESS cycle).
REQ-025 Unsupported opcodes: handling per REQ-031/REQ-032; loc_valid never asserted for them.

Reset
REQ-026 On nreset low, the FSM SHALL enter IDLE asynchronously, mid-transaction included; the in-flight transaction is discarded.
REQ-027 Reset values SHALL be: umi_out_valid 0, loc_valid 0, loc_write 0, umi_in_ready 1, umi_out_packet 0, loc_addr 0, loc_wrdata 0.
REQ-028 First request SHALL be accepted on the first rising edge after nreset deassertion.

Configuration
REQ-029 Macro UMI_ENDPOINT_ERR_EN SHALL select unsupported-opcode handling.
REQ-030 Under either setting, unsupported opcodes SHALL be accepted (umi_in_ready behaviour unchanged).
REQ-031 With UMI_ENDPOINT_ERR_EN defined: IDLE -> RESP directly; response cmd = RESP_ERR, addresses swapped, data zero.
REQ-032 Without it: packet dropped, FSM stays IDLE, no response.

Structure
REQ-033 Opcode constants and field bit offsets SHALL live in shared package umi_pkg.
REQ-034 Response packet assembly SHALL be sub-module umi_pack (cmd, dstaddr, srcaddr, data -> UW packet).

Verification
REQ-035 READ dstaddr 0x100, srcaddr 0x200, loc_ready immediate, loc_rddata 0xDEADBEEF -> loc_addr 0x100, loc_write 0; response 2 cycles later, cmd 0x04, dstaddr 0x200, srcaddr 0x100, data 0xDEADBEEF.
REQ-036 WRITE data 0x1234 to 0x40, loc_ready delayed 3 cycles -> loc_valid held 4 cycles with stable loc_wrdata 0x1234; response cmd 0x05, data 0.
REQ-037 POSTED_WRITE -> one local write, umi_out_valid stays 0, umi_in_ready returns 1 the cycle after loc handshake.
REQ-038 READ response with umi_out_ready low 5 cycles -> packet stable, umi_in_ready 0 throughout; new request accepted the cycle after transfer.
REQ-039 Opcode 0x7F -> with UMI_ENDPOINT_ERR_EN: cmd 0x06 response, no loc_valid; without: nothing observed.
REQ-040 nreset asserted during ACCESS -> loc_valid 0 and umi_in_ready 1 immediately; no response emitted afterwards.
